// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte-serial loads/stores over an 8-bit RAM port,
// registered MEM/WB triple, and a stall request while multi-byte accesses run.
module mem_stage #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wa,
  input  logic              we,
  input  logic [31:0]       res,
  input  logic [4:0]        ex_mem_e,
  input  logic [31:0]       ex_mem_n,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              stall_req,
  output logic [4:0]        wa_o,
  output logic              we_o,
  output logic [31:0]       wn_o
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t      st, st_nx;
  logic [1:0]  i, i_nx;
  logic [23:0] lbuf;
  logic [1:0]  off;
  logic        drv, done;
  logic [31:0] addr, ld_val;

  logic       en, wr, sgn;
  logic [1:0] len, lst;
  assign en  = ex_mem_e[4];
  assign len = ex_mem_e[3:2];
  assign wr  = ex_mem_e[1];
  assign sgn = ex_mem_e[0];
  // Index of the final byte: 0, 1 or 3 (len 10 behaves as a word).
  assign lst = {len[1], |len};

  assign addr = res + {30'd0, off};

  always_comb begin
    st_nx     = st;
    i_nx      = i;
    off       = 2'd0;
    drv       = 1'b0;
    done      = 1'b0;
    mem_wr    = 1'b0;
    stall_req = 1'b0;
    case (st)
      IDLE: begin
        if (en) begin
          drv = 1'b1;
          if (wr) begin
            mem_wr = 1'b1;
            if (lst == 2'd0) done = 1'b1;
            else begin
              stall_req = 1'b1;
              st_nx     = STORE;
              i_nx      = 2'd1;
            end
          end else begin
            stall_req = 1'b1;
            st_nx     = LOAD;
            i_nx      = 2'd0;
          end
        end else begin
          done = 1'b1;
        end
      end
      // In LOAD, i is the byte arriving on mem_din; the next address is issued alongside.
      LOAD: begin
        off = i + 2'd1;
        if (i == lst) begin
          done  = 1'b1;
          st_nx = IDLE;
          i_nx  = 2'd0;
        end else begin
          drv       = 1'b1;
          stall_req = 1'b1;
          i_nx      = i + 2'd1;
        end
      end
      STORE: begin
        off    = i;
        drv    = 1'b1;
        mem_wr = 1'b1;
        if (i == lst) begin
          done  = 1'b1;
          st_nx = IDLE;
          i_nx  = 2'd0;
        end else begin
          stall_req = 1'b1;
          i_nx      = i + 2'd1;
        end
      end
      default: st_nx = IDLE;
    endcase
    if (rst) begin
      mem_wr    = 1'b0;
      stall_req = 1'b0;
      drv       = 1'b0;
      done      = 1'b0;
    end
  end

  assign mem_a    = drv ? addr[ADDR_W-1:0] : '0;
  assign mem_dout = (drv && mem_wr) ? ex_mem_n[{off, 3'b000} +: 8] : 8'd0;

  always_comb begin
    case (lst)
      2'd0:    ld_val = sgn ? {24'd0, mem_din} : {{24{mem_din[7]}}, mem_din};
      2'd1:    ld_val = sgn ? {16'd0, mem_din, lbuf[7:0]}
                            : {{16{mem_din[7]}}, mem_din, lbuf[7:0]};
      default: ld_val = {mem_din, lbuf};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      i    <= 2'd0;
      lbuf <= 24'd0;
      wa_o <= 5'd0;
      we_o <= 1'b0;
      wn_o <= 32'd0;
    end else begin
      st <= st_nx;
      i  <= i_nx;
      if (st == LOAD && i != lst) begin
        case (i)
          2'd0:    lbuf[7:0]   <= mem_din;
          2'd1:    lbuf[15:8]  <= mem_din;
          default: lbuf[23:16] <= mem_din;
        endcase
      end
      if (done) begin
        wa_o <= wa;
        we_o <= (en && wr) ? 1'b0 : we;
        wn_o <= (en && !wr) ? ld_val : res;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-level RAM model plus per-op reference
// computed from little-endian load/store rules.
module tb_mem_stage;
  localparam int ADDR_W = 17;
  localparam int MSZ    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [4:0]        wa = '0;
  logic              we = 1'b0;
  logic [31:0]       res = '0;
  logic [4:0]        ex_mem_e = '0;
  logic [31:0]       ex_mem_n = '0;
  logic [7:0]        mem_din = '0;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic              stall_req;
  logic [4:0]        wa_o;
  logic              we_o;
  logic [31:0]       wn_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] phys [0:MSZ-1];
  logic [7:0] mdl  [0:MSZ-1];

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wa(wa), .we(we), .res(res),
    .ex_mem_e(ex_mem_e), .ex_mem_n(ex_mem_n), .mem_din(mem_din),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .stall_req(stall_req),
    .wa_o(wa_o), .we_o(we_o), .wn_o(wn_o)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (mem_wr) phys[mem_a] <= mem_dout;
    mem_din <= phys[mem_a];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] ec(input logic e, input logic [1:0] l, input logic w, input logic s);
    return {e, l, w, s};
  endfunction

  // Runs one op from cycle 0 to its completion edge and checks every cycle.
  task automatic do_op(input logic [4:0] owa, input logic owe, input logic [31:0] ores,
                       input logic [4:0] oe, input logic [31:0] on,
                       input logic use_lit, input logic [31:0] lit);
    logic        is_ld, is_st;
    int          nb, ncyc;
    logic [31:0] v, exp_wn, a;
    logic [7:0]  sd;
    logic        exp_we;
    is_ld = oe[4] && !oe[1];
    is_st = oe[4] && oe[1];
    nb = (oe[3:2] == 2'b00) ? 1 : (oe[3:2] == 2'b01) ? 2 : 4;
    exp_we = is_st ? 1'b0 : owe;
    exp_wn = ores;
    if (is_ld) begin
      v = 0;
      for (int k = 0; k < nb; k++) begin
        a = ores + k;
        v = v | (32'(mdl[a[ADDR_W-1:0]]) << (8 * k));
      end
      if (!oe[0] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!oe[0] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      exp_wn = v;
    end
    if (is_st) begin
      for (int k = 0; k < nb; k++) begin
        a = ores + k;
        mdl[a[ADDR_W-1:0]] = 8'((on >> (8 * k)) & 32'hFF);
      end
    end
    ncyc = is_ld ? nb + 1 : is_st ? nb : 1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin
        wa = owa; we = owe; res = ores; ex_mem_e = oe; ex_mem_n = on;
      end
      #1;
      if (is_ld) chk($sformatf("ld_stall c%0d", k), 32'(stall_req), 32'(k < nb));
      else if (is_st) chk($sformatf("st_stall c%0d", k), 32'(stall_req), 32'(k < nb - 1));
      else chk("alu_stall", 32'(stall_req), 0);
      chk($sformatf("mem_wr c%0d", k), 32'(mem_wr), 32'(is_st));
      if ((is_ld && k < nb) || is_st) begin
        a = ores + k;
        chk($sformatf("mem_a c%0d", k), 32'(mem_a), 32'(a[ADDR_W-1:0]));
      end
      if (is_st) begin
        sd = 8'((on >> (8 * k)) & 32'hFF);
        chk($sformatf("mem_dout c%0d", k), 32'(mem_dout), 32'(sd));
      end
    end
    @(posedge clk);
    #1;
    chk("wa_o", 32'(wa_o), 32'(owa));
    chk("we_o", 32'(we_o), 32'(exp_we));
    chk("wn_o", wn_o, exp_wn);
    if (use_lit) chk("wn_o_literal", wn_o, lit);
  endtask

  localparam logic [4:0] ALU = 5'b0_00_0_0;

  initial begin
    logic [4:0]  re;
    logic [31:0] rr;
    int          kind, mism;
    logic [7:0]  keep2, keep3;
    for (int k = 0; k < MSZ; k++) begin
      phys[k] = 8'($urandom);
      mdl[k]  = phys[k];
    end
    phys[17'h100] = 8'h80; phys[17'h101] = 8'h7F; phys[17'h102] = 8'h01; phys[17'h103] = 8'h02;
    mdl[17'h100]  = 8'h80; mdl[17'h101]  = 8'h7F; mdl[17'h102]  = 8'h01; mdl[17'h103]  = 8'h02;
    phys[17'h301] = 8'h12; mdl[17'h301] = 8'h12;

    // Reset state
    #2;
    chk("rst_wa_o", 32'(wa_o), 0);
    chk("rst_we_o", 32'(we_o), 0);
    chk("rst_wn_o", wn_o, 0);
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-computed results
    do_op(5'd5, 1'b1, 32'h0000_0123, ALU, 32'h0, 1'b1, 32'h0000_0123);
    do_op(5'd7, 1'b1, 32'h100, ec(1, 2'b11, 0, 0), 32'h0, 1'b1, 32'h0201_7F80);
    do_op(5'd8, 1'b1, 32'h100, ec(1, 2'b00, 0, 0), 32'h0, 1'b1, 32'hFFFF_FF80);
    do_op(5'd9, 1'b1, 32'h100, ec(1, 2'b00, 0, 1), 32'h0, 1'b1, 32'h0000_0080);
    do_op(5'd10, 1'b1, 32'h100, ec(1, 2'b01, 0, 0), 32'h0, 1'b1, 32'h0000_7F80);
    do_op(5'd11, 1'b1, 32'h200, ec(1, 2'b11, 1, 0), 32'hDEAD_BEEF, 1'b1, 32'h200);
    do_op(5'd12, 1'b1, 32'h200, ec(1, 2'b11, 0, 0), 32'h0, 1'b1, 32'hDEAD_BEEF);
    do_op(5'd13, 1'b1, 32'h300, ec(1, 2'b00, 1, 0), 32'h0000_00A5, 1'b1, 32'h300);
    do_op(5'd14, 1'b1, 32'h300, ec(1, 2'b01, 0, 0), 32'h0, 1'b1, 32'h0000_12A5);
    do_op(5'd15, 1'b1, 32'hFFFF_FFFE, ec(1, 2'b10, 0, 1), 32'h0, 1'b0, 32'h0);

    // Reset during cycle 2 of a word store
    keep2 = mdl[17'h402]; keep3 = mdl[17'h403];
    @(negedge clk);
    wa = 5'd3; we = 1'b1; res = 32'h400; ex_mem_e = ec(1, 2'b11, 1, 0); ex_mem_n = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_wn_o", wn_o, 0);
    chk("mid_rst_we_o", 32'(we_o), 0);
    chk("mid_rst_wa_o", 32'(wa_o), 0);
    chk("mid_rst_mem_wr", 32'(mem_wr), 0);
    chk("mid_rst_stall", 32'(stall_req), 0);
    chk("mid_rst_mem_a", 32'(mem_a), 0);
    chk("mid_rst_mem_dout", 32'(mem_dout), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ex_mem_e = ALU;
    chk("rst_ram400", 32'(phys[17'h400]), 32'h44);
    chk("rst_ram401", 32'(phys[17'h401]), 32'h33);
    chk("rst_ram402", 32'(phys[17'h402]), 32'(keep2));
    chk("rst_ram403", 32'(phys[17'h403]), 32'(keep3));
    mdl[17'h400] = 8'h44; mdl[17'h401] = 8'h33;
    do_op(5'd21, 1'b1, 32'h0000_0042, ALU, 32'h0, 1'b1, 32'h0000_0042);

    // Randomized back-to-back traffic; small address window to force store/load reuse
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 2);
      rr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + $urandom_range(0, 7))
                                       : (32'h0001_0000 + $urandom_range(0, 63));
      if (kind == 0) re = {1'b0, 4'($urandom)};
      else re = ec(1'b1, 2'($urandom), kind == 2, 1'($urandom));
      do_op(5'($urandom), 1'($urandom), rr, re, $urandom, 1'b0, 32'h0);
    end

    mism = 0;
    for (int k = 0; k < MSZ; k++) if (phys[k] !== mdl[k]) mism++;
    chk("ram_image", 32'(mism), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
